bp_me_dma_arb: RTL and testbench

BP_ME_DMA_ARB -- requirements
Module: bp_me_dma_arb

---
 rtl/bp_me_dma_arb.sv | 113 +++++++++++
 tb/tb_bp_me_dma_arb.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_dma_arb.sv
// Two-requester DMA arbiter (cache = 0, bypass = 1) sharing one packet, write and fill channel.
// Define BP_ME_DMA_ARB_RR_EN for round-robin tie-breaking; the default build uses fixed priority to bypass.
module bp_me_dma_arb #(
  parameter int addr_width_p  = 40,
  parameter int data_width_p  = 64,
  parameter int block_beats_p = 8
) (
  input  logic                                clk_i,
  input  logic                                reset_i,

  input  logic [1:0][addr_width_p:0]          req_dma_pkt_i,
  input  logic [1:0]                          req_dma_pkt_v_i,
  output logic [1:0]                          req_dma_pkt_ready_and_o,

  input  logic [1:0][data_width_p-1:0]        req_dma_data_i,
  input  logic [1:0]                          req_dma_data_v_i,
  output logic [1:0]                          req_dma_data_ready_and_o,

  output logic [1:0][data_width_p-1:0]        req_dma_data_o,
  output logic [1:0]                          req_dma_data_v_o,
  input  logic [1:0]                          req_dma_data_ready_and_i,

  output logic [addr_width_p:0]               dma_pkt_o,
  output logic                                dma_pkt_v_o,
  input  logic                                dma_pkt_ready_and_i,

  output logic [data_width_p-1:0]             dma_data_o,
  output logic                                dma_data_v_o,
  input  logic                                dma_data_ready_and_i,

  input  logic [data_width_p-1:0]             dma_data_i,
  input  logic                                dma_data_v_i,
  output logic                                dma_data_ready_and_o
);

  localparam int pkt_w = addr_width_p + 1;
  localparam int cnt_w = $clog2(block_beats_p + 1);
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(block_beats_p - 1);

  typedef enum logic [1:0] {e_idle, e_pkt, e_write, e_read} state_e;

  state_e           state_r;
  logic             grant_r;
  logic [cnt_w-1:0] cnt_r;
  logic             winner;
  logic             pkt_hs, wr_hs, rd_hs;

`ifdef BP_ME_DMA_ARB_RR_EN
  logic last_r;
  assign winner = (&req_dma_pkt_v_i) ? ~last_r : req_dma_pkt_v_i[1];
`else
  assign winner = req_dma_pkt_v_i[1];
`endif

  // NOTE: every output gets a default before the state-qualified overrides so no latch is inferred.
  always_comb begin
    dma_pkt_o                = req_dma_pkt_i[grant_r];
    dma_pkt_v_o              = (state_r == e_pkt) & req_dma_pkt_v_i[grant_r];
    req_dma_pkt_ready_and_o  = '0;
    dma_data_o               = req_dma_data_i[grant_r];
    dma_data_v_o             = (state_r == e_write) & req_dma_data_v_i[grant_r];
    req_dma_data_ready_and_o = '0;
    req_dma_data_o           = {dma_data_i, dma_data_i};
    req_dma_data_v_o         = '0;
    dma_data_ready_and_o     = (state_r == e_read) & req_dma_data_ready_and_i[grant_r];

    if (state_r == e_pkt)   req_dma_pkt_ready_and_o[grant_r]  = dma_pkt_ready_and_i;
    if (state_r == e_write) req_dma_data_ready_and_o[grant_r] = dma_data_ready_and_i;
    if (state_r == e_read)  req_dma_data_v_o[grant_r]         = dma_data_v_i;
  end

  assign pkt_hs = dma_pkt_v_o  & dma_pkt_ready_and_i;
  assign wr_hs  = dma_data_v_o & dma_data_ready_and_i;
  assign rd_hs  = dma_data_v_i & dma_data_ready_and_o;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: reset is asynchronous; all handshake outputs decode from state_r, so they drop with it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_idle;
      grant_r <= 1'b0;
      cnt_r   <= '0;
`ifdef BP_ME_DMA_ARB_RR_EN
      last_r  <= 1'b1;
`endif
    end else begin
      case (state_r)
        e_idle: if (|req_dma_pkt_v_i) begin
          grant_r <= winner;
          state_r <= e_pkt;
`ifdef BP_ME_DMA_ARB_RR_EN
          last_r  <= winner;
`endif
        end
        e_pkt: if (pkt_hs) begin
          cnt_r   <= '0;
          state_r <= req_dma_pkt_i[grant_r][pkt_w-1] ? e_write : e_read;
        end
        e_write, e_read: if ((state_r == e_write) ? wr_hs : rd_hs) begin
          // Wrap to 0 on the final beat so the counter never exceeds block_beats_p-1.
          if (cnt_r == last_beat) begin
            cnt_r   <= '0;
            state_r <= e_idle;
          end else begin
            cnt_r   <= cnt_r + cnt_w'(1);
          end
        end
        default: state_r <= e_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_me_dma_arb.sv
// Directed self-checking bench for bp_me_dma_arb: an 8-beat instance plus a single-beat instance.
module tb_bp_me_dma_arb;

  localparam int AW = 40;
  localparam int DW = 64;
  localparam int PW = AW + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0][PW-1:0] req_pkt;
  logic [1:0]         req_pkt_v, req_pkt_rdy;
  logic [1:0][DW-1:0] req_wdata;
  logic [1:0]         req_wdata_v, req_wdata_rdy;
  logic [1:0][DW-1:0] req_fill;
  logic [1:0]         req_fill_v, req_fill_rdy;
  logic [PW-1:0]      dma_pkt;
  logic               dma_pkt_v, dma_pkt_rdy;
  logic [DW-1:0]      dma_wdata;
  logic               dma_wdata_v, dma_wdata_rdy;
  logic [DW-1:0]      dma_fill;
  logic               dma_fill_v, dma_fill_rdy;

  logic [1:0]         b1_req_pkt_rdy, b1_req_wdata_rdy, b1_req_fill_v;
  logic [1:0][DW-1:0] b1_req_fill;
  logic [PW-1:0]      b1_dma_pkt;
  logic               b1_dma_pkt_v, b1_dma_wdata_v, b1_dma_fill_rdy;
  logic [DW-1:0]      b1_dma_wdata;

  logic [8:0] hs_outs, b1_hs_outs;
  assign hs_outs    = {dma_pkt_v, req_pkt_rdy, dma_wdata_v, req_wdata_rdy, req_fill_v, dma_fill_rdy};
  assign b1_hs_outs = {b1_dma_pkt_v, b1_req_pkt_rdy, b1_dma_wdata_v, b1_req_wdata_rdy,
                       b1_req_fill_v, b1_dma_fill_rdy};

  int errors = 0;
  int checks = 0;

  bp_me_dma_arb #(.addr_width_p(AW), .data_width_p(DW), .block_beats_p(8)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_dma_pkt_i(req_pkt), .req_dma_pkt_v_i(req_pkt_v), .req_dma_pkt_ready_and_o(req_pkt_rdy),
    .req_dma_data_i(req_wdata), .req_dma_data_v_i(req_wdata_v), .req_dma_data_ready_and_o(req_wdata_rdy),
    .req_dma_data_o(req_fill), .req_dma_data_v_o(req_fill_v), .req_dma_data_ready_and_i(req_fill_rdy),
    .dma_pkt_o(dma_pkt), .dma_pkt_v_o(dma_pkt_v), .dma_pkt_ready_and_i(dma_pkt_rdy),
    .dma_data_o(dma_wdata), .dma_data_v_o(dma_wdata_v), .dma_data_ready_and_i(dma_wdata_rdy),
    .dma_data_i(dma_fill), .dma_data_v_i(dma_fill_v), .dma_data_ready_and_o(dma_fill_rdy)
  );

  bp_me_dma_arb #(.addr_width_p(AW), .data_width_p(DW), .block_beats_p(1)) dut_b1 (
    .clk_i(clk), .reset_i(reset),
    .req_dma_pkt_i(req_pkt), .req_dma_pkt_v_i(req_pkt_v), .req_dma_pkt_ready_and_o(b1_req_pkt_rdy),
    .req_dma_data_i(req_wdata), .req_dma_data_v_i(req_wdata_v), .req_dma_data_ready_and_o(b1_req_wdata_rdy),
    .req_dma_data_o(b1_req_fill), .req_dma_data_v_o(b1_req_fill_v), .req_dma_data_ready_and_i(req_fill_rdy),
    .dma_pkt_o(b1_dma_pkt), .dma_pkt_v_o(b1_dma_pkt_v), .dma_pkt_ready_and_i(dma_pkt_rdy),
    .dma_data_o(b1_dma_wdata), .dma_data_v_o(b1_dma_wdata_v), .dma_data_ready_and_i(dma_wdata_rdy),
    .dma_data_i(dma_fill), .dma_data_v_i(dma_fill_v), .dma_data_ready_and_o(b1_dma_fill_rdy)
  );

  task automatic idle_inputs();
    req_pkt       = '0;
    req_pkt_v     = '0;
    req_wdata     = '0;
    req_wdata_v   = '0;
    req_fill_rdy  = '0;
    dma_pkt_rdy   = 1'b0;
    dma_wdata_rdy = 1'b0;
    dma_fill      = '0;
    dma_fill_v    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    req_pkt_v = 2'b11; req_wdata_v = 2'b11; req_fill_rdy = 2'b11;
    dma_pkt_rdy = 1'b1; dma_wdata_rdy = 1'b1; dma_fill_v = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (hs_outs !== 9'h0 || b1_hs_outs !== 9'h0) begin
        errors++;
        $display("FAIL reset_outs[%0d]: got %h/%h expected 000/000", c, hs_outs, b1_hs_outs);
      end
      @(negedge clk);
    end
    idle_inputs();
    reset = 1'b0;
  endtask

  task automatic test_read_cache();
    logic [PW-1:0] pkt;
    pkt = {1'b0, 40'h00_8000_0040};
    do_reset();
    @(negedge clk);
    req_pkt[0] = pkt; req_pkt_v = 2'b01; dma_pkt_rdy = 1'b1; req_wdata[0] = 64'hDEAD;
    #1; checks++;
    if (hs_outs !== 9'h0) begin
      errors++; $display("FAIL rd_idle_outs: got %h expected 000", hs_outs);
    end
    @(negedge clk); #1; checks++;
    if (dma_pkt_v !== 1'b1 || req_pkt_rdy !== 2'b01 || dma_pkt !== pkt) begin
      errors++; $display("FAIL rd_pkt: got v=%b rdy=%b pkt=%h expected v=1 rdy=01 pkt=%h",
                         dma_pkt_v, req_pkt_rdy, dma_pkt, pkt);
    end
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      req_pkt_v = 2'b00; dma_fill_v = 1'b1; dma_fill = DW'(b); req_fill_rdy = 2'b11;
      #1; checks++;
      if (req_fill_v !== 2'b01 || req_fill[0] !== DW'(b) || dma_fill_rdy !== 1'b1 || dma_wdata_v !== 1'b0) begin
        errors++; $display("FAIL rd_beat[%0d]: got v=%b data=%h rdy=%b expected v=01 data=%h rdy=1",
                           b, req_fill_v, req_fill[0], dma_fill_rdy, DW'(b));
      end
    end
    @(negedge clk); #1; checks++;
    if (dma_fill_rdy !== 1'b0 || req_fill_v !== 2'b00) begin
      errors++; $display("FAIL rd_done_idle: got rdy=%b v=%b expected rdy=0 v=00", dma_fill_rdy, req_fill_v);
    end
    idle_inputs();
  endtask

  task automatic test_write_bypass();
    logic [PW-1:0] pkt;
    int k, cyc;
    logic exp_rdy;
    pkt = {1'b1, 40'h100};
    do_reset();
    @(negedge clk);
    req_pkt[1] = pkt; req_pkt_v = 2'b10; dma_pkt_rdy = 1'b1; req_wdata[0] = 64'hDEAD;
    @(negedge clk); #1; checks++;
    if (dma_pkt_v !== 1'b1 || req_pkt_rdy !== 2'b10 || dma_pkt !== pkt) begin
      errors++; $display("FAIL wr_pkt: got v=%b rdy=%b pkt=%h expected v=1 rdy=10 pkt=%h",
                         dma_pkt_v, req_pkt_rdy, dma_pkt, pkt);
    end
    k = 0; cyc = 0;
    while (k < 8 && cyc < 40) begin
      @(negedge clk);
      exp_rdy = (cyc % 2 == 1);
      req_pkt_v = 2'b00; req_wdata_v = 2'b10; req_wdata[1] = DW'(8'hA0 + k); dma_wdata_rdy = exp_rdy;
      #1; checks++;
      if (dma_wdata_v !== 1'b1 || req_wdata_rdy !== {exp_rdy, 1'b0} || dma_fill_rdy !== 1'b0) begin
        errors++; $display("FAIL wr_hs[%0d]: got v=%b rdy=%b expected v=1 rdy=%b0",
                           cyc, dma_wdata_v, req_wdata_rdy, exp_rdy);
      end
      if (exp_rdy) begin
        checks++;
        if (dma_wdata !== DW'(8'hA0 + k)) begin
          errors++; $display("FAIL wr_data[%0d]: got %h expected %h", k, dma_wdata, DW'(8'hA0 + k));
        end
        k++;
      end
      cyc++;
    end
    checks++;
    if (k !== 8) begin
      errors++; $display("FAIL wr_beats: got %0d expected 8", k);
    end
    @(negedge clk);
    dma_wdata_rdy = 1'b1;
    #1; checks++;
    if (dma_wdata_v !== 1'b0 || req_wdata_rdy !== 2'b00) begin
      errors++; $display("FAIL wr_done_idle: got v=%b rdy=%b expected v=0 rdy=00", dma_wdata_v, req_wdata_rdy);
    end
    idle_inputs();
  endtask

  task automatic test_hold_grant();
    logic [PW-1:0] pkt0, pkt1;
    pkt0 = {1'b0, 40'h40};
    pkt1 = {1'b0, 40'h200};
    do_reset();
    @(negedge clk);
    req_pkt[0] = pkt0; req_pkt[1] = pkt1; req_pkt_v = 2'b01; dma_pkt_rdy = 1'b1;
    @(negedge clk); #1; checks++;
    if (req_pkt_rdy !== 2'b01 || dma_pkt !== pkt0) begin
      errors++; $display("FAIL hold_pkt0: got rdy=%b pkt=%h expected rdy=01 pkt=%h", req_pkt_rdy, dma_pkt, pkt0);
    end
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      req_pkt_v = 2'b10; dma_fill_v = 1'b1; dma_fill = DW'(b); req_fill_rdy = 2'b01;
      #1; checks++;
      if (req_pkt_rdy !== 2'b00 || dma_pkt_v !== 1'b0 || req_fill_v !== 2'b01) begin
        errors++; $display("FAIL hold_beat[%0d]: got pkt_rdy=%b pkt_v=%b fill_v=%b expected 00/0/01",
                           b, req_pkt_rdy, dma_pkt_v, req_fill_v);
      end
    end
    @(negedge clk);
    dma_fill_v = 1'b0;
    #1; checks++;
    if (req_pkt_rdy !== 2'b00 || dma_pkt_v !== 1'b0) begin
      errors++; $display("FAIL hold_idle: got rdy=%b v=%b expected 00/0", req_pkt_rdy, dma_pkt_v);
    end
    @(negedge clk); #1; checks++;
    if (req_pkt_rdy !== 2'b10 || dma_pkt_v !== 1'b1 || dma_pkt !== pkt1) begin
      errors++; $display("FAIL hold_next_grant: got rdy=%b v=%b pkt=%h expected 10/1/%h",
                         req_pkt_rdy, dma_pkt_v, dma_pkt, pkt1);
    end
    idle_inputs();
  endtask

  task automatic test_arbitration();
    logic [PW-1:0] pkt0, pkt1;
    logic exp_g;
    pkt0 = {1'b0, 40'h1000};
    pkt1 = {1'b0, 40'h2000};
    do_reset();
    req_pkt[0] = pkt0; req_pkt[1] = pkt1; req_fill_rdy = 2'b11;
    for (int t = 0; t < 4; t++) begin
`ifdef BP_ME_DMA_ARB_RR_EN
      exp_g = (t % 2 == 1);
`else
      exp_g = 1'b1;
`endif
      @(negedge clk);
      dma_fill_v = 1'b0; req_pkt_v = 2'b11; dma_pkt_rdy = 1'b1;
      @(negedge clk); #1; checks++;
      if (dma_pkt !== (exp_g ? pkt1 : pkt0) || req_pkt_rdy !== (exp_g ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL arb_grant[%0d]: got pkt=%h rdy=%b expected grant %0d",
                           t, dma_pkt, req_pkt_rdy, exp_g);
      end
      for (int b = 0; b < 8; b++) begin
        @(negedge clk);
        dma_fill_v = 1'b1; dma_fill = DW'(b);
        #1; checks++;
        if (req_fill_v !== (exp_g ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL arb_beat[%0d.%0d]: got v=%b expected grant %0d", t, b, req_fill_v, exp_g);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    logic [PW-1:0] rpkt, wpkt;
    rpkt = {1'b0, 40'h300};
    wpkt = {1'b1, 40'h300};
    do_reset();
    @(negedge clk);
    req_pkt[0] = rpkt; req_pkt_v = 2'b01; dma_pkt_rdy = 1'b1; req_fill_rdy = 2'b01;
    @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      req_pkt_v = 2'b00; dma_fill_v = 1'b1; dma_fill = DW'(b);
    end
    @(negedge clk);
    reset = 1'b1; req_pkt_v = 2'b01; req_wdata_v = 2'b11; dma_wdata_rdy = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1; checks++;
      if (hs_outs !== 9'h0) begin
        errors++; $display("FAIL rstmid_outs[%0d]: got %h expected 000", c, hs_outs);
      end
      @(negedge clk);
    end
    req_pkt[0] = wpkt; req_pkt_v = 2'b01; req_wdata_v = 2'b00; dma_fill_v = 1'b0;
    reset = 1'b0;
    @(negedge clk); #1; checks++;
    if (dma_pkt_v !== 1'b1 || dma_pkt !== wpkt || req_pkt_rdy !== 2'b01) begin
      errors++; $display("FAIL rstmid_pkt: got v=%b pkt=%h rdy=%b expected 1/%h/01",
                         dma_pkt_v, dma_pkt, req_pkt_rdy, wpkt);
    end
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      req_pkt_v = 2'b00; req_wdata_v = 2'b01; req_wdata[0] = DW'(8'h10 + b);
      #1; checks++;
      if (dma_wdata_v !== 1'b1 || dma_wdata !== DW'(8'h10 + b) || req_wdata_rdy !== 2'b01) begin
        errors++; $display("FAIL rstmid_wr[%0d]: got v=%b data=%h rdy=%b expected 1/%h/01",
                           b, dma_wdata_v, dma_wdata, req_wdata_rdy, DW'(8'h10 + b));
      end
    end
    @(negedge clk); #1; checks++;
    if (dma_wdata_v !== 1'b0 || req_wdata_rdy !== 2'b00) begin
      errors++; $display("FAIL rstmid_idle: got v=%b rdy=%b expected 0/00", dma_wdata_v, req_wdata_rdy);
    end
    idle_inputs();
  endtask

  task automatic test_single_beat();
    logic [PW-1:0] pkt;
    pkt = {1'b0, 40'h400};
    do_reset();
    @(negedge clk);
    dma_fill_v = 1'b1; dma_fill = 64'h55; req_fill_rdy = 2'b01;
    #1; checks++;
    if (b1_dma_fill_rdy !== 1'b0 || b1_req_fill_v !== 2'b00) begin
      errors++; $display("FAIL b1_stray: got rdy=%b v=%b expected 0/00", b1_dma_fill_rdy, b1_req_fill_v);
    end
    @(negedge clk);
    req_pkt[0] = pkt; req_pkt_v = 2'b01; dma_pkt_rdy = 1'b1;
    @(negedge clk); #1; checks++;
    if (b1_dma_pkt_v !== 1'b1 || b1_dma_pkt !== pkt || b1_dma_fill_rdy !== 1'b0) begin
      errors++; $display("FAIL b1_pkt: got v=%b pkt=%h fill_rdy=%b expected 1/%h/0",
                         b1_dma_pkt_v, b1_dma_pkt, b1_dma_fill_rdy, pkt);
    end
    @(negedge clk);
    req_pkt_v = 2'b00;
    #1; checks++;
    if (b1_dma_fill_rdy !== 1'b1 || b1_req_fill_v !== 2'b01 || b1_req_fill[0] !== 64'h55) begin
      errors++; $display("FAIL b1_beat: got rdy=%b v=%b data=%h expected 1/01/55",
                         b1_dma_fill_rdy, b1_req_fill_v, b1_req_fill[0]);
    end
    @(negedge clk); #1; checks++;
    if (b1_dma_fill_rdy !== 1'b0 || b1_req_fill_v !== 2'b00) begin
      errors++; $display("FAIL b1_done_idle: got rdy=%b v=%b expected 0/00", b1_dma_fill_rdy, b1_req_fill_v);
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_read_cache();
    test_write_bypass();
    test_hold_grant();
    test_arbitration();
    test_reset_mid();
    test_single_beat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
